// File: rtl/div_32.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, sign applied to the quotient on completion.
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for ctrl_DIV; outputs hold the last result
  // RUN   | one restoring step per edge, counter 0..WIDTH-1
  // DONE  | publish signed quotient and exception, pulse data_resultRDY
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CNT_W-1:0] cnt;
  logic             sign;
  logic             div_zero;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             b_zero;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_next;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1).
  always_comb begin
    abs_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    abs_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
    b_zero = (data_operandB == '0);
  end

  // rem < dvs always holds, so the WIDTH-bit difference never loses a bit.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, dvs});
    rem_diff  = rem_shift[WIDTH-1:0] - dvs;
    rem_next  = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      dvd            <= '0;
      dvs            <= '0;
      rem            <= '0;
      quo            <= '0;
      cnt            <= '0;
      sign           <= 1'b0;
      div_zero       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      // A start strobe always wins: any in-flight operation is dropped silently.
      if (ctrl_DIV) begin
        dvd      <= abs_a;
        dvs      <= abs_b;
        sign     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= b_zero;
        rem      <= '0;
        quo      <= '0;
        cnt      <= '0;
        busy     <= 1'b1;
        state    <= b_zero ? DONE : RUN;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            rem <= rem_next;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            quo <= {quo[WIDTH-2:0], rem_ge};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= DONE;
            end
          end
          DONE: begin
            data_result    <= sign ? (~quo + WIDTH'(1)) : quo;
            data_exception <= div_zero;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_32.sv
// Directed bench for div_32: vector table for quotient/exception/latency,
// plus abort, back-to-back start and asynchronous reset sequences.
module tb_div_32;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the start edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0000_0000;
    check("busy after start", {31'd0, busy}, 32'd1);
  endtask

  // Counts edges until data_resultRDY is seen; lat = -1 if it never comes.
  task automatic wait_rdy(output int lat, output int busy_low);
    lat      = -1;
    busy_low = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) begin
        lat = n;
        break;
      end
      if (!busy) busy_low++;
    end
  endtask

  task automatic count_rdy(input int cycles, output int pulses);
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
  endtask

  task automatic run_vec(input int idx);
    int lat;
    int blow;
    start_op(vecs[idx].a, vecs[idx].b);
    wait_rdy(lat, blow);
    check($sformatf("vec%0d latency", idx), lat, vecs[idx].lat);
    check($sformatf("vec%0d busy gaps", idx), blow, 0);
    check($sformatf("vec%0d result", idx), data_result, vecs[idx].q);
    check($sformatf("vec%0d exception", idx), {31'd0, data_exception}, {31'd0, vecs[idx].exc});
    check($sformatf("vec%0d busy at rdy", idx), {31'd0, busy}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check($sformatf("vec%0d rdy width", idx), {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int lat;
    int blow;
    int pulses;
    logic [31:0] held;

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         1'b0, 33};
    vecs[1]  = '{-32'sd100,      32'd7,          32'hFFFF_FFF2,  1'b0, 33};
    vecs[2]  = '{32'd100,        -32'sd7,        32'hFFFF_FFF2,  1'b0, 33};
    vecs[3]  = '{-32'sd100,      -32'sd7,        32'd14,         1'b0, 33};
    vecs[4]  = '{32'd7,          32'd100,        32'd0,          1'b0, 33};
    vecs[5]  = '{32'd5,          32'd0,          32'd0,          1'b1, 1};
    vecs[6]  = '{32'd9,          32'd3,          32'd3,          1'b0, 33};
    vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 33};
    vecs[8]  = '{32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, 33};
    vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 33};
    vecs[10] = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
    vecs[11] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0, 33};
    vecs[12] = '{-32'sd7,        32'd2,          32'hFFFF_FFFD,  1'b0, 33};
    vecs[13] = '{32'd0,          32'd5,          32'd0,          1'b0, 33};
    vecs[14] = '{32'h7FFF_FFFF,  32'd3,          32'h2AAA_AAAA,  1'b0, 33};

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1;
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'd0, data_exception}, 32'd0);
    check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 15; i++) begin
      run_vec(i);
    end

    // Outputs hold between operations.
    held = data_result;
    repeat (5) @(negedge clock);
    check("result hold", data_result, 32'h2AAA_AAAA);
    check("result hold stable", data_result, held);

    // Restart mid-run: 1000/10 at E0, 9/3 at E10, RDY only at E43.
    start_op(32'd1000, 32'd10);
    count_rdy(9, pulses);
    check("abort no early rdy", pulses, 0);
    start_op(32'd9, 32'd3);
    wait_rdy(lat, blow);
    check("abort latency from restart", lat, 33);
    check("abort result", data_result, 32'd3);
    check("abort busy gaps", blow, 0);
    @(posedge clock);
    @(negedge clock);

    // Start on the RDY cycle: old result completes, new one follows.
    start_op(32'd100, 32'd7);
    wait_rdy(lat, blow);
    check("b2b first result", data_result, 32'd14);
    start_op(32'd81, -32'sd9);
    check("b2b rdy dropped", {31'd0, data_resultRDY}, 32'd0);
    check("b2b old result held", data_result, 32'd14);
    wait_rdy(lat, blow);
    check("b2b second latency", lat, 33);
    check("b2b second result", data_result, 32'hFFFF_FFF7);
    @(posedge clock);
    @(negedge clock);

    // Divide by zero sets exception; next valid divide clears it.
    start_op(32'd5, 32'd0);
    wait_rdy(lat, blow);
    check("dz latency", lat, 1);
    check("dz exception", {31'd0, data_exception}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    check("dz busy low", {31'd0, busy}, 32'd0);
    check("dz exception held", {31'd0, data_exception}, 32'd1);

    // Async reset mid-cycle during a run.
    start_op(32'd100, 32'd7);
    wait_rdy(lat, blow);
    @(posedge clock);
    @(negedge clock);
    start_op(32'd50, 32'd5);
    repeat (19) begin
      @(posedge clock);
      @(negedge clock);
    end
    #2;
    reset = 1'b1;
    #1;
    check("async rst result", data_result, 32'd0);
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst rdy", {31'd0, data_resultRDY}, 32'd0);
    check("async rst exception", {31'd0, data_exception}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    count_rdy(40, pulses);
    check("no rdy after reset", pulses, 0);
    check("idle busy after reset", {31'd0, busy}, 32'd0);
    start_op(32'd50, 32'd5);
    wait_rdy(lat, blow);
    check("post reset latency", lat, 33);
    check("post reset result", data_result, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
